// File: rtl/gfx_fetch_pkg.sv
// gfx_fetch_pkg: shared types for the graphics-ROM fetch arbiter.
// FSM state, requester indices, line-tag width, round-robin helpers.
package gfx_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIT  = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [1:0] REQ_A = 2'd0;
    localparam logic [1:0] REQ_B = 2'd1;
    localparam logic [1:0] REQ_S = 2'd2;

    localparam int TAG_W = 20;

    function automatic logic [1:0] rr_next(input logic [1:0] g);
        return (g == REQ_S) ? REQ_A : g + 2'd1;
    endfunction

    // First asserted request scanning upward from ptr, mod 3.
    function automatic logic [1:0] rr_pick(
        input logic [2:0] r,
        input logic [1:0] ptr
    );
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        idx   = ptr;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
            idx = rr_next(idx);
        end
        return sel;
    endfunction

endpackage

// File: rtl/gfx_line_buf.sv
// gfx_line_buf: one-entry 64-bit line buffer with tag compare.
// Ports: clk/rst_n, flush, fill + fill_tag/fill_data, look_tag -> hit, line.
module gfx_line_buf
    import gfx_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             fill,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic [63:0]      fill_data,
    input  logic [TAG_W-1:0] look_tag,
    output logic             hit,
    output logic [63:0]      line
);

    logic             valid;
    logic [TAG_W-1:0] tag;

    // Flush wins over a simultaneous fill so a reload never
    // leaves a stale line marked valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            line  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            line  <= fill_data;
        end
    end

    assign hit = valid && (tag == look_tag);

endmodule

// File: rtl/gfx_fetch_arbiter.sv
// gfx_fetch_arbiter: round-robin share of the gfx-ROM SDRAM port
// between layer A, layer B and sprites, with per-requester line buffers.
// Ports: CLK_32M/RESET_N; req/addr in, data/rdy out per requester;
// flush; sdr_addr/sdr_req out, sdr_data/sdr_rdy in.
module gfx_fetch_arbiter
    import gfx_fetch_pkg::*;
#(
    parameter int          N_REQ       = 3,
    parameter logic [24:0] BASE_A      = 25'h0100000,
    parameter logic [24:0] BASE_B      = 25'h0100000,
    parameter logic [24:0] BASE_S      = 25'h0500000,
    parameter bit          LINE_BUF_EN = 1'b1
) (
    input  logic                   CLK_32M,
    input  logic                   RESET_N,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0][20:0] addr,
    output logic [N_REQ-1:0][31:0] data,
    output logic [N_REQ-1:0]       rdy,
    input  logic                   flush,
    output logic [24:0]            sdr_addr,
    output logic                   sdr_req,
    input  logic [63:0]            sdr_data,
    input  logic                   sdr_rdy
);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        rr;
    logic [1:0]        gnt;
    logic [1:0]        pick;
    logic [20:0]       gaddr;
    logic [N_REQ-1:0]  req_eff;
    logic [N_REQ-1:0]  hit_vec;
    logic [N_REQ-1:0]  fill_en;
    logic [N_REQ-1:0][63:0] lb_line;
    logic              any_req;
    logic              pick_hit;
    logic              done;

    function automatic logic [24:0] base_of(input logic [1:0] i);
        case (i)
            REQ_A:   return BASE_A;
            REQ_B:   return BASE_B;
            default: return BASE_S;
        endcase
    endfunction

    // A requester is ignored in its own rdy cycle.
    assign req_eff  = req & ~rdy;
    assign any_req  = |req_eff;
    assign pick     = rr_pick(req_eff, rr);
    // A flush in the lookup cycle already counts as invalidated.
    assign pick_hit = LINE_BUF_EN && !flush && hit_vec[pick];
    assign done     = (state == WAIT) && sdr_rdy;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lb
        gfx_line_buf u_lb (
            .clk      (CLK_32M),
            .rst_n    (RESET_N),
            .flush    (flush),
            .fill     (fill_en[i]),
            .fill_tag (gaddr[20:1]),
            .fill_data(sdr_data),
            .look_tag (addr[i][20:1]),
            .hit      (hit_vec[i]),
            .line     (lb_line[i])
        );
    end

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (any_req) state_nxt = pick_hit ? HIT : WAIT;
            end
            HIT:  state_nxt = IDLE;
            WAIT: begin
                if (sdr_rdy) state_nxt = GAP;
            end
            GAP:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sdr_req = (state == WAIT);
        fill_en = '0;
        for (int i = 0; i < N_REQ; i++) begin
            fill_en[i] = done && (gnt == 2'(i));
        end
    end

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            rr       <= REQ_A;
            gnt      <= REQ_A;
            gaddr    <= '0;
            sdr_addr <= '0;
            rdy      <= '0;
            data     <= '0;
        end else begin
            rdy <= '0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt   <= pick;
                        gaddr <= addr[pick];
                        // Carry out of bit 24 is dropped on purpose.
                        if (!pick_hit) begin
                            sdr_addr <= base_of(pick)
                                      + {2'b00, addr[pick][20:1], 3'b000};
                        end
                    end
                end
                HIT: begin
                    rdy[gnt]  <= 1'b1;
                    data[gnt] <= gaddr[0] ? lb_line[gnt][63:32]
                                          : lb_line[gnt][31:0];
                    rr        <= rr_next(gnt);
                end
                WAIT: begin
                    if (sdr_rdy) begin
                        rdy[gnt]  <= 1'b1;
                        data[gnt] <= gaddr[0] ? sdr_data[63:32]
                                              : sdr_data[31:0];
                        rr        <= rr_next(gnt);
                    end
                end
                GAP: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gfx_fetch_arbiter.sv
// tb_gfx_fetch_arbiter: directed bench for gfx_fetch_arbiter.
// Bench plays the requesters and the SDRAM controller by hand.
module tb_gfx_fetch_arbiter;

    logic             clk;
    logic             rst_n;
    logic [2:0]       req;
    logic [2:0][20:0] addr;
    logic [2:0][31:0] data;
    logic [2:0]       rdy;
    logic             flush;
    logic [24:0]      sdr_addr;
    logic             sdr_req;
    logic [63:0]      sdr_data;
    logic             sdr_rdy;

    int n_tests = 0;
    int n_fail  = 0;
    int sreq_cnt = 0;

    gfx_fetch_arbiter #(
        .N_REQ      (3),
        .BASE_A     (25'h0000000),
        .BASE_B     (25'h0100000),
        .BASE_S     (25'h1FFFFF8),
        .LINE_BUF_EN(1'b1)
    ) dut (
        .CLK_32M (clk),
        .RESET_N (rst_n),
        .req     (req),
        .addr    (addr),
        .data    (data),
        .rdy     (rdy),
        .flush   (flush),
        .sdr_addr(sdr_addr),
        .sdr_req (sdr_req),
        .sdr_data(sdr_data),
        .sdr_rdy (sdr_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (sdr_req) sreq_cnt++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_sreq(input string tag, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!sdr_req && cyc < 20);
        chk(tag, {63'd0, sdr_req}, 64'd1);
    endtask

    task automatic reply(input logic [63:0] d, input int lat,
                         input logic fl);
        for (int k = 1; k < lat; k++) tick();
        sdr_data = d;
        sdr_rdy  = 1'b1;
        flush    = fl;
        tick();
        sdr_rdy  = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        int          cyc;
        int          snap;
        int          g;
        logic [20:0] cur [3];
        logic [24:0] base_v [3];
        logic [24:0] ea;
        logic [31:0] lo;

        rst_n    = 1'b0;
        req      = '0;
        addr     = '0;
        flush    = 1'b0;
        sdr_data = '0;
        sdr_rdy  = 1'b0;
        base_v[0] = 25'h0000000;
        base_v[1] = 25'h0100000;
        base_v[2] = 25'h1FFFFF8;

        #12;
        chk("rst_sdr_req",  {63'd0, sdr_req}, 64'd0);
        chk("rst_sdr_addr", {39'd0, sdr_addr}, 64'd0);
        chk("rst_rdy",      {61'd0, rdy}, 64'd0);
        chk("rst_data0",    {32'd0, data[0]}, 64'd0);
        chk("rst_data2",    {32'd0, data[2]}, 64'd0);
        #10 rst_n = 1'b1;
        tick();

        // Single miss on A.
        req[0]  = 1'b1;
        addr[0] = 21'h000005;
        wait_sreq("miss_sreq", cyc);
        chk("miss_lat", 64'(cyc), 64'd1);
        chk("miss_addr", {39'd0, sdr_addr}, 64'h10);
        reply(64'hAAAA_BBBB_1111_2222, 4, 1'b0);
        chk("miss_rdy",  {61'd0, rdy}, 64'b001);
        chk("miss_data", {32'd0, data[0]}, 64'hAAAA_BBBB);
        chk("miss_sreq_drop", {63'd0, sdr_req}, 64'd0);
        req[0] = 1'b0;
        tick();
        chk("miss_rdy_once", {61'd0, rdy}, 64'd0);
        chk("miss_gap", {63'd0, sdr_req}, 64'd0);
        tick();

        // Same line, other half: hit.
        snap    = sreq_cnt;
        req[0]  = 1'b1;
        addr[0] = 21'h000004;
        tick();
        chk("hit_rdy_early", {61'd0, rdy}, 64'd0);
        tick();
        chk("hit_rdy",  {61'd0, rdy}, 64'b001);
        chk("hit_data", {32'd0, data[0]}, 64'h1111_2222);
        chk("hit_no_sreq", 64'(sreq_cnt - snap), 64'd0);
        req[0] = 1'b0;
        tick();

        // Sprite base wrap: carry out of 25 bits dropped.
        req[2]  = 1'b1;
        addr[2] = 21'h000002;
        wait_sreq("wrap_sreq", cyc);
        chk("wrap_addr", {39'd0, sdr_addr}, 64'h0);
        reply(64'h0123_4567_89AB_CDEF, 2, 1'b0);
        chk("wrap_rdy",  {61'd0, rdy}, 64'b100);
        chk("wrap_data", {32'd0, data[2]}, 64'h89AB_CDEF);
        req[2] = 1'b0;
        tick();
        tick();

        // Flush coinciding with sdr_rdy.
        req[0]  = 1'b1;
        addr[0] = 21'h000041;
        wait_sreq("fl_sreq", cyc);
        chk("fl_addr", {39'd0, sdr_addr}, 64'h100);
        reply(64'hDEAD_BEEF_CAFE_F00D, 3, 1'b1);
        chk("fl_rdy",  {61'd0, rdy}, 64'b001);
        chk("fl_data", {32'd0, data[0]}, 64'hDEAD_BEEF);
        req[0] = 1'b0;
        tick();
        tick();
        req[0] = 1'b1;
        wait_sreq("fl_remiss", cyc);
        chk("fl_remiss_lat", 64'(cyc), 64'd1);
        reply(64'h5555_6666_7777_8888, 2, 1'b0);
        chk("fl_re_data", {32'd0, data[0]}, 64'h5555_6666);
        req[0] = 1'b0;
        tick();
        tick();
        snap    = sreq_cnt;
        req[0]  = 1'b1;
        addr[0] = 21'h000040;
        tick();
        tick();
        chk("fill_hit_rdy",  {61'd0, rdy}, 64'b001);
        chk("fill_hit_data", {32'd0, data[0]}, 64'h7777_8888);
        chk("fill_hit_nosr", 64'(sreq_cnt - snap), 64'd0);
        req[0] = 1'b0;
        tick();

        // Reset while B is waiting on SDRAM.
        req[1]  = 1'b1;
        addr[1] = 21'h000008;
        wait_sreq("rw_sreq", cyc);
        chk("rw_addr", {39'd0, sdr_addr}, 64'h0100020);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_sreq_low", {63'd0, sdr_req}, 64'd0);
        chk("rw_rdy_low",  {61'd0, rdy}, 64'd0);
        req[1] = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        req[0]  = 1'b1;
        addr[0] = 21'h000041;
        wait_sreq("rw_post_miss", cyc);
        chk("rw_post_lat", 64'(cyc), 64'd1);
        reply(64'h0000_0001_0000_0002, 2, 1'b0);
        chk("rw_post_data", {32'd0, data[0]}, 64'h1);
        req[0] = 1'b0;
        tick();
        tick();

        // Fresh reset so the rr pointer starts at A.
        rst_n = 1'b0;
        #2;
        chk("rst2_data0", {32'd0, data[0]}, 64'd0);
        #2 rst_n = 1'b1;
        tick();

        // All three requesting continuously.
        cur[0] = 21'h000010;
        cur[1] = 21'h000020;
        cur[2] = 21'h000030;
        for (int i = 0; i < 3; i++) addr[i] = cur[i];
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            g  = k % 3;
            ea = base_v[g] + {2'b00, cur[g][20:1], 3'b000};
            lo = 32'(k + 100);
            wait_sreq($sformatf("rr%0d_sreq", k), cyc);
            chk($sformatf("rr%0d_addr", k), {39'd0, sdr_addr},
                {39'd0, ea});
            reply({32'(k), lo}, 2, 1'b0);
            chk($sformatf("rr%0d_rdy", k), {61'd0, rdy},
                64'(3'b001 << g));
            chk($sformatf("rr%0d_data", k), {32'd0, data[g]},
                {32'd0, lo});
            cur[g]  = cur[g] + 21'd2;
            addr[g] = cur[g];
        end
        req = '0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
